// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state
// encoding, iteration count and the quotient returned on divide-by-zero.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // One quotient bit is produced per CALC cycle.
    localparam int DIV_ITER = 32;

    // Wide enough to hold the iteration index 0..DIV_ITER-1 with headroom.
    localparam int CNT_W = 6;

    // Quotient reported when the divisor is zero, in either mode.
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    // Absolute value of a two's complement operand when signed, raw value
    // otherwise. 0x80000000 maps onto itself, which is the correct unsigned
    // magnitude 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] value,
                                              input logic        is_signed);
        if (is_signed && value[31]) begin
            return ~value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift the next dividend
// bit into the partial remainder, try to subtract the divisor, and keep the
// difference only when it does not go negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             quot_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             unused_top;

    // Trial subtraction carries an extra bit so its sign is the borrow out;
    // when the trial fails the shifted remainder is below the divisor, so
    // its top bit is always zero and the low WIDTH bits are sufficient.
    always_comb begin
        shifted    = {rem, dividend_msb};
        trial      = {1'b0, shifted} - {2'b00, divisor};
        quot_bit   = ~trial[WIDTH+1];
        rem_next   = quot_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        unused_top = trial[WIDTH] ^ shifted[WIDTH];
    end

endmodule

// File: rtl/div_unit.sv
// Sequential 32-bit integer divider for MIPS div/divu. Operands are reduced
// to magnitudes on start, divided with one restoring step per cycle, then
// sign-corrected in a final FIX cycle that also registers the results.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quot_shift;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] orig_dividend;
    logic             neg_quot;
    logic             neg_rem;
    logic             zero_divisor;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    // The dividend magnitude shifts out of quot_shift MSB-first while the
    // quotient bits shift in at the bottom, so one register serves both.
    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem          (part_rem),
        .dividend_msb (quot_shift[WIDTH-1]),
        .divisor      (divisor_mag),
        .rem_next     (step_rem),
        .quot_bit     (step_bit)
    );

    // Controller FSM with registered outputs; reset discards any operation
    // in flight and takes priority over a simultaneous start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            count         <= '0;
            part_rem      <= '0;
            quot_shift    <= '0;
            divisor_mag   <= '0;
            orig_dividend <= '0;
            neg_quot      <= 1'b0;
            neg_rem       <= 1'b0;
            zero_divisor  <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            quotient_o    <= '0;
            remainder_o   <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        neg_quot      <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                        neg_rem       <= signed_i & dividend_i[WIDTH-1];
                        zero_divisor  <= (divisor_i == '0);
                        orig_dividend <= dividend_i;
                        quot_shift    <= magnitude(dividend_i, signed_i);
                        divisor_mag   <= magnitude(divisor_i, signed_i);
                        part_rem      <= '0;
                        count         <= '0;
                        busy_o        <= 1'b1;
                        state         <= CALC;
                    end
                end

                CALC: begin
                    part_rem   <= step_rem;
                    quot_shift <= {quot_shift[WIDTH-2:0], step_bit};
                    count      <= count + 1'b1;
                    if (count == CNT_W'(DIV_ITER - 1)) begin
                        state <= FIX;
                    end
                end

                FIX: begin
                    if (zero_divisor) begin
                        quotient_o    <= DIV_ZERO_QUOT;
                        remainder_o   <= orig_dividend;
                        div_by_zero_o <= 1'b1;
                    end else begin
                        quotient_o    <= neg_quot ? (~quot_shift + 1'b1) : quot_shift;
                        remainder_o   <= neg_rem  ? (~part_rem + 1'b1)   : part_rem;
                        div_by_zero_o <= 1'b0;
                    end
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized operands
// against an arithmetic reference model, ignored starts, back-to-back
// issue and reset during a calculation.
module tb_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_by_zero_o;

    int vectors     = 0;
    int miscompares = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .signed_i      (signed_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: MIPS div/divu semantics from plain integer arithmetic.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic s, output logic [31:0] q,
                                    output logic [31:0] r, output logic z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // Issues one request from #1 after an edge and waits for done_o.
    // poke_at > 0 pulses a second start with other operands at that cycle.
    // Returns with the caller #1 after the edge on which done_o was seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int poke_at, output int latency, output int busy_cnt);
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk_i);
        #1;
        start_i    = 1'b0;
        signed_i   = $urandom_range(0, 1);
        dividend_i = $urandom;
        divisor_i  = $urandom;
        busy_cnt   = busy_o ? 1 : 0;
        latency    = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == poke_at) begin
                start_i    = 1'b1;
                signed_i   = 1'b0;
                dividend_i = 32'd99;
                divisor_i  = 32'd9;
            end
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            if (busy_o) busy_cnt++;
            if (done_o) begin
                latency = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd10; divisor_i = 32'd3;
        repeat (3) @(posedge clk_i);
        #1;
        start_i = 1'b0;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
        vectors++; if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
        vectors++; if (quotient_o !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_q got %h want 0", quotient_o); end
        vectors++; if (remainder_o !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_r got %h want 0", remainder_o); end
        vectors++; if (div_by_zero_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dbz got %b want 0", div_by_zero_o); end
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h1234, 32'd9,
                                32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] tb [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'd3,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        logic        ts [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] eq, er;
        logic        ez;
        int          lat, bcnt;
        for (int i = 0; i < 8; i++) begin
            ref_div(ta[i], tb[i], ts[i], eq, er, ez);
            run_op(ta[i], tb[i], ts[i], 0, lat, bcnt);
            vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL dir%0d_latency got %0d want 33", i, lat); end
            vectors++; if (bcnt !== 33) begin miscompares++; $display("[TB] FAIL dir%0d_busy_cycles got %0d want 33", i, bcnt); end
            vectors++; if (quotient_o !== eq) begin miscompares++; $display("[TB] FAIL dir%0d_q got %h want %h", i, quotient_o, eq); end
            vectors++; if (remainder_o !== er) begin miscompares++; $display("[TB] FAIL dir%0d_r got %h want %h", i, remainder_o, er); end
            vectors++; if (div_by_zero_o !== ez) begin miscompares++; $display("[TB] FAIL dir%0d_dbz got %b want %b", i, div_by_zero_o, ez); end
            @(posedge clk_i);
            #1;
            vectors++; if (done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL dir%0d_done_pulse got %b want 0", i, done_o); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        logic        s, ez;
        int          lat, bcnt;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 255));
                2: b = -32'($urandom_range(1, 255));
                default: b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            ref_div(a, b, s, eq, er, ez);
            run_op(a, b, s, 0, lat, bcnt);
            vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL rnd%0d_latency got %0d want 33", i, lat); end
            vectors++;
            if (quotient_o !== eq || remainder_o !== er || div_by_zero_o !== ez) begin
                miscompares++;
                $display("[TB] FAIL rnd%0d_result %h/%h s=%b got q=%h r=%h z=%b want q=%h r=%h z=%b",
                         i, a, b, s, quotient_o, remainder_o, div_by_zero_o, eq, er, ez);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat, bcnt;
        run_op(32'd50, 32'd5, 1'b0, 10, lat, bcnt);
        vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL ignore_latency got %0d want 33", lat); end
        vectors++; if (quotient_o !== 32'd10) begin miscompares++; $display("[TB] FAIL ignore_q got %h want %h", quotient_o, 32'd10); end
        vectors++; if (remainder_o !== 32'd0) begin miscompares++; $display("[TB] FAIL ignore_r got %h want 0", remainder_o); end
        // A queued start would show up as a second busy period.
        repeat (3) @(posedge clk_i);
        #1;
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_not_queued busy got %b want 0", busy_o); end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_op(32'd1000, 32'd33, 1'b0, 0, lat, bcnt);
        vectors++; if (quotient_o !== 32'd30 || remainder_o !== 32'd10) begin
            miscompares++; $display("[TB] FAIL b2b_first got q=%h r=%h want q=%h r=%h", quotient_o, remainder_o, 32'd30, 32'd10);
        end
        run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, lat, bcnt);
        vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL b2b_latency got %0d want 33", lat); end
        vectors++; if (bcnt !== 33) begin miscompares++; $display("[TB] FAIL b2b_busy_cycles got %0d want 33", bcnt); end
        vectors++; if (quotient_o !== 32'hFFFF_FFF2 || remainder_o !== 32'hFFFF_FFFE) begin
            miscompares++; $display("[TB] FAIL b2b_second got q=%h r=%h want q=fffffff2 r=fffffffe", quotient_o, remainder_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        int seen_done = 0;
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd12345; divisor_i = 32'd17;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (14) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        vectors++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_ctrl got busy=%b done=%b want 0 0", busy_o, done_o);
        end
        vectors++; if (quotient_o !== 32'd0 || remainder_o !== 32'd0 || div_by_zero_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midreset_outputs got q=%h r=%h z=%b want 0", quotient_o, remainder_o, div_by_zero_o);
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) seen_done++;
        end
        vectors++; if (seen_done !== 0) begin miscompares++; $display("[TB] FAIL midreset_no_done got %0d pulses want 0", seen_done); end
        run_op(32'd12345, 32'd17, 1'b0, 0, lat, bcnt);
        vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL post_reset_latency got %0d want 33", lat); end
        vectors++; if (quotient_o !== 32'd726 || remainder_o !== 32'd3) begin
            miscompares++; $display("[TB] FAIL post_reset_result got q=%0d r=%0d want q=726 r=3", quotient_o, remainder_o);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; dividend_i = '0; divisor_i = '0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Sequential 32-bit integer divider serving the MIPS `div`/`divu` instructions, the inverse of the ALU's combinational `mul` path. It sits beside the ALU in the execute stage; the controller issues a start pulse, stalls while `busy_o` is high, and writes `quotient_o`/`remainder_o` into LO/HI when `done_o` pulses. The unit uses a restoring algorithm that produces one quotient bit per cycle, with sign correction applied afterwards.

## Interface
- `WIDTH`, 32: operand and result width; only 32 is verified.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  request a division; sampled only in IDLE.
- `signed_i`  in  1  1 = `div` (two's complement), 0 = `divu`; captured with `start_i`.
- `dividend_i`  in  32  dividend; captured with `start_i`.
- `divisor_i`  in  32  divisor; captured with `start_i`.
- `busy_o`  out  1  high in CALC and FIX; reset 0.
- `done_o`  out  1  one-cycle pulse when results update; reset 0.
- `quotient_o`  out  32  quotient (goes to LO); reset 0; held until the next completion.
- `remainder_o`  out  32  remainder (goes to HI); reset 0; held until the next completion.
- `div_by_zero_o`  out  1  high when the last completed operation had divisor 0; reset 0; held with the results.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start_i`=1:
  - latch the sign flags;
  - load the magnitudes `|dividend|` and `|divisor|` (raw values when `signed_i`=0);
  - set partial remainder = 0 and the iteration counter = 0;
  - go to CALC.
- CALC, each cycle:
  - shift {remainder, dividend-shift} left by 1;
  - trial = remainder − divisor (33-bit);
  - if trial ≥ 0, remainder = trial and shift in 1; otherwise shift in 0;
  - counter +1; after the 32nd iteration, go to FIX.
- FIX:
  - negate the quotient if signed and the operand signs differ;
  - negate the remainder if signed and the dividend is negative (truncation toward zero; the remainder takes the dividend's sign);
  - register the outputs, pulse `done_o`, return to IDLE.
- Divisor 0, either mode: `quotient_o`=0xFFFFFFFF, `remainder_o`=original `dividend_i`, `div_by_zero_o`=1. The full latency still applies.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: `quotient_o`=0x80000000, `remainder_o`=0, `div_by_zero_o`=0.
- `start_i` in CALC or FIX is ignored; it is not queued.
- Operand inputs may change freely after the start cycle.

## Timing
- `start_i` sampled at edge N:
  - `busy_o`=1 from after edge N;
  - CALC iterations occur at edges N+1 … N+32;
  - FIX at edge N+33: results valid, `done_o`=1, `busy_o`=0;
  - `done_o` returns to 0 at edge N+34.
- Fixed latency: 33 cycles from start to done, for all operands.
- Back-to-back: `start_i` is accepted in the same cycle that `done_o` is high, because the state is IDLE.
- `rst_i` at any edge, including mid-CALC:
  - state goes to IDLE and all outputs clear to 0;
  - the in-flight operation is discarded and no `done_o` is produced;
  - `rst_i` dominates a simultaneous `start_i`.

## Structure
- Shared package `div_pkg`: state encoding (IDLE=2'd0, CALC=2'd1, FIX=2'd2), `DIV_ITER`=32, and the divide-by-zero quotient constant 32'hFFFFFFFF.
- One sub-module, `div_step`: a purely combinational single restoring iteration.
  - Inputs: remainder, dividend MSB, divisor.
  - Outputs: next remainder, quotient bit.
- The top level holds the FSM, the counter, the magnitude/sign logic and the output registers.

## Test plan
- Unsigned 100 ÷ 7 → `done_o` exactly 33 cycles after start; q=14, r=2, `busy_o` high for 33 cycles.
- Signed −7 ÷ 2, i.e. 0xFFFFFFF9 / 0x2 → q=0xFFFFFFFD, r=0xFFFFFFFF. Signed 7 ÷ −2 → q=0xFFFFFFFD, r=1.
- Divide by zero: unsigned 0x1234 ÷ 0 → q=0xFFFFFFFF, r=0x1234, `div_by_zero_o`=1. The next normal operation (9 ÷ 3) clears the flag and returns q=3, r=0.
- Signed 0x80000000 ÷ 0xFFFFFFFF → q=0x80000000, r=0. Unsigned, same operands → q=0, r=0x80000000.
- Start 50 ÷ 5, then pulse `start_i` with 99 ÷ 9 at cycle 10 → the second request is ignored; q=10, r=0. A new start issued during the `done_o` cycle completes 33 cycles later.
- Assert `rst_i` at cycle 15 of an operation → all outputs 0 on the next cycle, no `done_o` pulse, and the next start behaves normally.
